// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared op encoding and widths for the tag lookup unit
package cache_pkg;

    typedef enum logic [1:0] {
        OP_LOOKUP = 2'b00,
        OP_FILL   = 2'b01,
        OP_INVAL  = 2'b10
    } tag_op_e;

    localparam int STAT_W = 32;

endpackage

// File: rtl/plru_tree.sv
// rtl/plru_tree.sv - combinational tree pseudo-LRU victim pick and access update
module plru_tree #(
    parameter  int N_WAYS = 4,
    localparam int WAY_W  = $clog2(N_WAYS)
) (
    input  logic [N_WAYS-2:0] tree,
    input  logic [WAY_W-1:0]  access_way,
    input  logic              access_en,
    output logic [WAY_W-1:0]  victim,
    output logic [N_WAYS-2:0] tree_next
);

    // Heap-numbered nodes: node n lives in tree[n-1], children are 2n and 2n+1.
    logic [WAY_W:0]   walk_node;
    logic [WAY_W:0]   upd_node;
    logic [WAY_W-1:0] walk_idx;
    logic [WAY_W-1:0] upd_idx;

    always_comb begin
        walk_node = (WAY_W+1)'(1);
        walk_idx  = '0;
        for (int l = 0; l < WAY_W; l++) begin
            walk_idx  = walk_node[WAY_W-1:0] - WAY_W'(1);
            walk_node = {walk_node[WAY_W-1:0], tree[walk_idx]};
        end
        victim = walk_node[WAY_W-1:0];
    end

    always_comb begin
        tree_next = tree;
        upd_node  = (WAY_W+1)'(1);
        upd_idx   = '0;
        if (access_en) begin
            for (int l = WAY_W - 1; l >= 0; l--) begin
                upd_idx            = upd_node[WAY_W-1:0] - WAY_W'(1);
                tree_next[upd_idx] = ~access_way[l];
                upd_node           = {upd_node[WAY_W-1:0], access_way[l]};
            end
        end
    end

endmodule

// File: rtl/tag_lookup_unit.sv
// rtl/tag_lookup_unit.sv - registered set-associative tag store with PLRU; TAG_LOOKUP_STATS_EN adds hit/miss counters
module tag_lookup_unit
    import cache_pkg::*;
#(
    parameter  int N_WAYS   = 4,
    parameter  int N_SETS   = 16,
    parameter  int TAG_BITS = 21,
    localparam int WAY_W    = $clog2(N_WAYS),
    localparam int SET_W    = $clog2(N_SETS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [1:0]          req_op,
    input  logic [SET_W-1:0]    req_set,
    input  logic [TAG_BITS-1:0] req_tag,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic                resp_hit,
    output logic [WAY_W-1:0]    resp_way,
    output logic [WAY_W-1:0]    resp_victim,
    output logic                resp_multi_hit
`ifdef TAG_LOOKUP_STATS_EN
    ,
    output logic [STAT_W-1:0]   stat_hits,
    output logic [STAT_W-1:0]   stat_misses
`endif
);

    logic [N_WAYS-1:0]   valid_q [N_SETS];
    logic [TAG_BITS-1:0] tag_q   [N_SETS][N_WAYS];
    logic [N_WAYS-2:0]   plru_q  [N_SETS];

    logic              accept;
    logic [N_WAYS-1:0] match;
    logic              hit, multi;
    logic [WAY_W-1:0]  hit_way, inv_way, plru_victim, victim;
    logic [WAY_W-1:0]  access_way, way_d;
    logic              access_en, do_write, do_inval, hit_d, multi_d;
    logic [N_WAYS-2:0] plru_next;

    assign req_ready = !flush && (!resp_valid || resp_ready);
    assign accept    = req_valid && req_ready;

    always_comb begin
        match = '0;
        for (int w = 0; w < N_WAYS; w++) begin
            match[w] = valid_q[req_set][w] && (tag_q[req_set][w] == req_tag);
        end
    end

    // Descending scan leaves the lowest qualifying index.
    always_comb begin
        hit_way = '0;
        inv_way = '0;
        for (int w = N_WAYS - 1; w >= 0; w--) begin
            if (match[w]) hit_way = WAY_W'(w);
            if (!valid_q[req_set][w]) inv_way = WAY_W'(w);
        end
    end

    assign hit    = |match;
    assign multi  = |(match & (match - N_WAYS'(1)));
    assign victim = (~&valid_q[req_set]) ? inv_way : plru_victim;

    always_comb begin
        access_en  = 1'b0;
        access_way = hit_way;
        do_write   = 1'b0;
        do_inval   = 1'b0;
        hit_d      = 1'b0;
        way_d      = '0;
        multi_d    = multi;
        case (req_op)
            OP_LOOKUP: begin
                hit_d = hit;
                if (hit) begin
                    access_en = 1'b1;
                    way_d     = hit_way;
                end
            end
            OP_FILL: begin
                access_en = 1'b1;
                hit_d     = hit;
                if (hit) begin
                    way_d = hit_way;
                end else begin
                    way_d      = victim;
                    access_way = victim;
                    do_write   = 1'b1;
                end
            end
            OP_INVAL: begin
                hit_d = hit;
                if (hit) begin
                    do_inval = 1'b1;
                    way_d    = hit_way;
                end
            end
            default: multi_d = 1'b0;
        endcase
    end

    plru_tree #(.N_WAYS(N_WAYS)) u_plru (
        .tree       (plru_q[req_set]),
        .access_way (access_way),
        .access_en  (access_en),
        .victim     (plru_victim),
        .tree_next  (plru_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < N_SETS; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
            resp_valid     <= 1'b0;
            resp_hit       <= 1'b0;
            resp_way       <= '0;
            resp_victim    <= '0;
            resp_multi_hit <= 1'b0;
        end else begin
            if (flush) begin
                for (int s = 0; s < N_SETS; s++) begin
                    valid_q[s] <= '0;
                    plru_q[s]  <= '0;
                end
            end else if (accept) begin
                if (do_write) valid_q[req_set][access_way] <= 1'b1;
                if (do_inval) valid_q[req_set][hit_way]    <= 1'b0;
                plru_q[req_set] <= plru_next;
            end
            if (accept) begin
                resp_valid     <= 1'b1;
                resp_hit       <= hit_d;
                resp_way       <= way_d;
                resp_victim    <= victim;
                resp_multi_hit <= multi_d;
            end else if (resp_ready) begin
                resp_valid <= 1'b0;
            end
        end
    end

    // Tag array carries no reset; valid bits alone qualify its contents.
    always_ff @(posedge clk) begin
        if (accept && do_write) tag_q[req_set][access_way] <= req_tag;
    end

`ifdef TAG_LOOKUP_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_hits   <= '0;
            stat_misses <= '0;
        end else if (flush) begin
            stat_hits   <= '0;
            stat_misses <= '0;
        end else if (accept && req_op == OP_LOOKUP) begin
            if (hit && !(&stat_hits))     stat_hits   <= stat_hits + 1'b1;
            if (!hit && !(&stat_misses))  stat_misses <= stat_misses + 1'b1;
        end
    end
`endif

endmodule

// File: doc/tag_lookup_unit.md
Name: tag_lookup_unit

Overview:
Registered successor to the combinational tag comparator. Holds a set-associative tag store (valid bit and tag per set/way) and accepts LOOKUP, FILL and INVALIDATE requests over a valid/ready handshake. Returns hit/way/victim one cycle later and maintains tree pseudo-LRU replacement state per set. Sits between the cache controller FSM and the data array.

Parameters:
N_WAYS, 4, associativity; power of 2, >= 2
N_SETS, 16, number of sets; power of 2, >= 2
TAG_BITS, 21, tag width
WAY_W, $clog2(N_WAYS), derived way-index width (localparam)
SET_W, $clog2(N_SETS), derived set-index width (localparam)

Ports:
clk  in  1  single clock; all state on rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  clear all valid bits and PLRU state
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid && req_ready
req_op  in  2  tag_op_e: LOOKUP / FILL / INVAL
req_set  in  SET_W  set index
req_tag  in  TAG_BITS  tag to compare or write
resp_valid  out  1  response present
resp_ready  in  1  response consumed when resp_valid && resp_ready
resp_hit  out  1  tag matched a valid way at accept time
resp_way  out  WAY_W  hit way, or written way for FILL
resp_victim  out  WAY_W  replacement candidate at accept time
resp_multi_hit  out  1  more than one valid way matched (error)

Behaviour:
- Reset (async, rst_n=0): all valid bits 0, all PLRU bits 0, resp_valid=0, resp_hit=0, resp_way=0, resp_victim=0, resp_multi_hit=0. Tag storage is not reset.
- req_ready = !flush && (!resp_valid || resp_ready). This is a one-entry output register with full throughput.
- Compare, victim selection and state update all use array contents at the accept edge. The response registers load on that same edge, giving a latency of exactly 1 cycle.
- Back-to-back requests to the same set see the previous request's updates.
- Hit: valid[set][w] && tag[set][w]==req_tag. resp_way is the lowest matching index. resp_multi_hit is set when two or more ways match.
- Victim: lowest-index invalid way if any. Otherwise the way pointed to by the set's PLRU tree (bit 0 steers left, 1 steers right).
- LOOKUP: on hit, update PLRU to point away from resp_way. On miss, no state change; resp_way=0.
- FILL, tag absent: write req_tag into the victim way, set valid, update PLRU away from that way. Response: hit=0, resp_way=written way.
- FILL, tag present: no write, PLRU refreshed, hit=1, resp_way=matching way. A duplicate tag is never created.
- INVAL: on hit, clear valid of the matching way; PLRU unchanged; hit=1. On miss, no state change.
- Op 2'b11 (reserved): accepted; response hit=0, no state change.
- flush=1: clears all valid bits and PLRU bits at the edge, and no request is accepted that cycle. A pending response is held and still delivered.
- resp_* are stable while resp_valid && !resp_ready.
- Reset mid-transaction drops any pending response.

Optional Feature:
TAG_LOOKUP_STATS_EN
- Defined: adds outputs stat_hits[31:0] and stat_misses[31:0]. Each counts accepted LOOKUPs by outcome, saturates at 32'hFFFF_FFFF, and clears on rst_n and on flush.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- cache_pkg:
  - tag_op_e enum (OP_LOOKUP=2'b00, OP_FILL=2'b01, OP_INVAL=2'b10)
  - STAT_W=32
- Sub-module plru_tree (combinational, parametrised by N_WAYS):
  - inputs: tree bits, access way, access enable
  - outputs: victim way, next tree bits
  - tag_lookup_unit instantiates it once, on the selected set's tree.

Test Plan:
1. Reset, then LOOKUP set 3 tag 0x1ABCD -> resp one cycle later, hit=0, victim=0, multi_hit=0.
2. FILL set 3 with tags 0x10,0x11,0x12,0x13 back-to-back with resp_ready=1 -> resp_way 0,1,2,3 on consecutive cycles; then LOOKUP 0x12 -> hit=1, way=2.
3. Set 3 full: LOOKUP 0x10, LOOKUP 0x12, then FILL 0x20 -> writes PLRU victim way 1 (N_WAYS=4); LOOKUP 0x11 -> miss.
4. FILL existing tag 0x13 -> hit=1, way=3, no duplicate; INVAL 0x13 -> hit=1; LOOKUP 0x13 -> miss, victim=3.
5. Hold resp_ready=0 with a response pending -> req_ready=0, resp fields stable for 5 cycles; release -> next request accepted the same cycle.
6. Assert flush while req_valid=1 -> request not accepted that cycle; afterwards every LOOKUP misses. With TAG_LOOKUP_STATS_EN, counters read 0.
